// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef logic [1:0] ds_state_t;
    localparam ds_state_t DS_IDLE = 2'd0;
    localparam ds_state_t DS_ERR1 = 2'd1;
    localparam ds_state_t DS_ERR2 = 2'd2;

endpackage

// File: rtl/ahb_decoder_mux_if.sv
// Bus bundle between the AHB master, the decoder/mux and the slave array.
interface ahb_decoder_mux_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    logic [ADDR_W-1:0]            haddr;
    logic [1:0]                   htrans;
    logic [NUM_SLAVES-1:0]        hsel;
    logic [NUM_SLAVES*DATA_W-1:0] hrdata_s;
    logic [NUM_SLAVES-1:0]        hreadyout_s;
    logic [NUM_SLAVES-1:0]        hresp_s;
    logic [DATA_W-1:0]            hrdata;
    logic                         hready;
    logic                         hresp;

    // Environment side: master plus slave array.
    modport master (
        output haddr, htrans, hrdata_s, hreadyout_s, hresp_s,
        input  hsel, hrdata, hready, hresp
    );

    // Decoder/mux side.
    modport slave (
        input  haddr, htrans, hrdata_s, hreadyout_s, hresp_s,
        output hsel, hrdata, hready, hresp
    );
endinterface

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped regions: two-cycle ERROR response and a saturating error count.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       hclk,
    input  logic       hresetn,
    input  logic       sel,
    input  logic [1:0] htrans,
    input  logic       hready,
    output logic       hreadyout,
    output logic       hresp,
    output logic [7:0] err_cnt
);

    ds_state_t state;
    ds_state_t state_nxt;
    logic      active_req;

    assign active_req = hready && sel &&
                        ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

    // ERR2 re-enters ERR1 for a back-to-back unmapped transfer; anything else drops to IDLE.
    always_comb begin
        state_nxt = DS_IDLE;
        if (state == DS_ERR1)
            state_nxt = DS_ERR2;
        else if (active_req)
            state_nxt = DS_ERR1;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state   <= DS_IDLE;
            err_cnt <= '0;
        end else begin
            state <= state_nxt;
            if ((state_nxt == DS_ERR1) && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

    assign hreadyout = (state != DS_ERR1);
    assign hresp     = (state == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder, data-phase select register and slave-to-master response mux.
module ahb_decoder_mux
    import ahb_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int IDX_LSB    = 28,
    parameter int IDX_W      = 3
) (
    input  logic           hclk,
    input  logic           hresetn,
    ahb_decoder_mux_if.slave bus,
    output logic [7:0]     err_cnt
);

    if ((NUM_SLAVES < 1) || (NUM_SLAVES >= (1 << IDX_W))) begin : g_bad_cfg
        $error("ahb_decoder_mux: NUM_SLAVES must be in 1..2^IDX_W-1");
    end

    localparam logic [IDX_W-1:0] SLAVE_LIMIT = IDX_W'(NUM_SLAVES);

    logic [IDX_W-1:0]      idx;
    logic [NUM_SLAVES-1:0] hsel_dec;
    logic                  def_sel;
    logic [NUM_SLAVES:0]   dsel;
    logic                  ds_hreadyout;
    logic                  ds_hresp;

    assign idx     = bus.haddr[IDX_LSB +: IDX_W];
    assign def_sel = (idx >= SLAVE_LIMIT);

    always_comb begin
        hsel_dec = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++)
            hsel_dec[i] = (idx == IDX_W'(i));
    end

    assign bus.hsel = hsel_dec;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)
            dsel <= '0;
        else if (bus.hready)
            dsel <= {def_sel, hsel_dec};
    end

    ahb_default_slave u_default_slave (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .sel       (def_sel),
        .htrans    (bus.htrans),
        .hready    (bus.hready),
        .hreadyout (ds_hreadyout),
        .hresp     (ds_hresp),
        .err_cnt   (err_cnt)
    );

    // With no data-phase owner the master sees a zero-wait OKAY.
    always_comb begin
        bus.hrdata = '0;
        bus.hready = 1'b1;
        bus.hresp  = HRESP_OKAY;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (dsel[i]) begin
                bus.hrdata = bus.hrdata_s[i*DATA_W +: DATA_W];
                bus.hready = bus.hreadyout_s[i];
                bus.hresp  = bus.hresp_s[i];
            end
        end
        if (dsel[NUM_SLAVES]) begin
            bus.hready = ds_hreadyout;
            bus.hresp  = ds_hresp;
        end
    end

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed bench for ahb_decoder_mux with a per-cycle reference model of data-phase ownership.
module tb_ahb_decoder_mux;
    import ahb_pkg::*;

    localparam int NS = 4;
    localparam int DW = 32;

    logic       hclk = 1'b0;
    logic       hresetn = 1'b0;
    logic [7:0] err_cnt;

    int tests = 0;
    int fails = 0;

    ahb_decoder_mux_if #(.NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(DW)) bus ();

    ahb_decoder_mux #(
        .NUM_SLAVES (NS),
        .ADDR_W     (32),
        .DATA_W     (DW),
        .IDX_LSB    (28),
        .IDX_W      (3)
    ) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus),
        .err_cnt (err_cnt)
    );

    always #5 hclk = ~hclk;

    // Model: owner -1 = nobody, 0..NS-1 = mapped slave, NS = default slave.
    // err_phase 0 = no error, 1 = first (wait) cycle, 2 = second (ready) cycle.
    int m_owner = -1;
    int m_phase = 0;
    int m_errs  = 0;

    function automatic int region(input logic [31:0] a);
        return int'((a >> 28) % 8);
    endfunction

    function automatic logic [NS-1:0] exp_hsel(input logic [31:0] a);
        if (region(a) < NS) return NS'(1 << region(a));
        return '0;
    endfunction

    function automatic logic exp_hready();
        if (m_owner < 0) return 1'b1;
        if (m_owner == NS) return (m_phase != 1);
        return bus.hreadyout_s[m_owner];
    endfunction

    function automatic logic exp_hresp();
        if (m_owner < 0) return 1'b0;
        if (m_owner == NS) return (m_phase != 0);
        return bus.hresp_s[m_owner];
    endfunction

    function automatic logic [31:0] exp_hrdata();
        if (m_owner < 0 || m_owner == NS) return 32'h0;
        return bus.hrdata_s[m_owner*DW +: DW];
    endfunction

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            m_owner = -1;
            m_phase = 0;
            m_errs  = 0;
        end else if (exp_hready()) begin
            m_owner = (region(bus.haddr) < NS) ? region(bus.haddr) : NS;
            if (m_owner == NS && bus.htrans[1]) begin
                m_phase = 1;
                if (m_errs < 255) m_errs++;
            end else begin
                m_phase = 0;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    bit run_cmp = 1'b1;
    always @(negedge hclk) begin
        if (run_cmp) begin
            check("model_hsel",   32'(bus.hsel),   32'(exp_hsel(bus.haddr)));
            check("model_hrdata", bus.hrdata,      exp_hrdata());
            check("model_hready", 32'(bus.hready), 32'(exp_hready()));
            check("model_hresp",  32'(bus.hresp),  32'(exp_hresp()));
            check("model_errcnt", 32'(err_cnt),    32'(m_errs));
        end
    end

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t);
        bus.haddr  = a;
        bus.htrans = t;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [31:0] sweep_addr [5] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000,
                                    32'h3000_0000, 32'h5000_0000};
    logic [3:0]  sweep_sel  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

    initial begin
        drive(32'h0, HTRANS_IDLE);
        bus.hreadyout_s = '0;
        bus.hresp_s     = '0;
        for (int i = 0; i < NS; i++)
            bus.hrdata_s[i*DW +: DW] = 32'h1111_0000 + 32'(i);

        // Reset with every slave stalling
        #3;
        check("rst_hready", 32'(bus.hready), 32'd1);
        check("rst_hresp",  32'(bus.hresp),  32'd0);
        check("rst_hrdata", bus.hrdata,      32'd0);
        check("rst_errcnt", 32'(err_cnt),    32'd0);
        @(negedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;
        bus.hreadyout_s = '1;
        step();

        // Decode sweep
        for (int i = 0; i < 5; i++) begin
            drive(sweep_addr[i], HTRANS_IDLE);
            #1;
            check("decode_hsel", 32'(bus.hsel), 32'(sweep_sel[i]));
        end
        step();

        // Mapped read, slave 2 waits two cycles
        drive(32'h2000_0010, HTRANS_NONSEQ);
        bus.hreadyout_s[2] = 1'b0;
        step();
        drive(32'h0000_0000, HTRANS_IDLE);
        #1;
        check("wait1_hready", 32'(bus.hready), 32'd0);
        step();
        check("wait2_hready", 32'(bus.hready), 32'd0);
        check("wait2_hsel",   32'(bus.hsel),   32'b0001);
        step();
        bus.hreadyout_s[2] = 1'b1;
        bus.hrdata_s[2*DW +: DW] = 32'hA5A5_A5A5;
        #1;
        check("wait3_hready", 32'(bus.hready), 32'd1);
        check("wait3_hrdata", bus.hrdata,      32'hA5A5_A5A5);
        step();

        // Unmapped NONSEQ: two-cycle ERROR
        drive(32'h6000_0000, HTRANS_NONSEQ);
        step();
        drive(32'h0000_0000, HTRANS_IDLE);
        check("err1_hready", 32'(bus.hready), 32'd0);
        check("err1_hresp",  32'(bus.hresp),  32'd1);
        check("err1_errcnt", 32'(err_cnt),    32'd1);
        step();
        check("err2_hready", 32'(bus.hready), 32'd1);
        check("err2_hresp",  32'(bus.hresp),  32'd1);
        step();
        check("after_err_hresp", 32'(bus.hresp), 32'd0);

        // IDLE to unmapped region: zero-wait OKAY
        drive(32'h6000_0000, HTRANS_IDLE);
        step();
        check("idle_unm_hready", 32'(bus.hready), 32'd1);
        check("idle_unm_hresp",  32'(bus.hresp),  32'd0);
        check("idle_unm_errcnt", 32'(err_cnt),    32'd1);
        drive(32'h0000_0000, HTRANS_IDLE);
        step();

        // Back-to-back errors
        drive(32'h7000_0000, HTRANS_NONSEQ);
        step();
        drive(32'h7000_0004, HTRANS_SEQ);
        check("b2b_a_err1", 32'({bus.hready, bus.hresp}), 32'b01);
        step();
        check("b2b_a_err2", 32'({bus.hready, bus.hresp}), 32'b11);
        step();
        drive(32'h0000_0000, HTRANS_IDLE);
        check("b2b_b_err1", 32'({bus.hready, bus.hresp}), 32'b01);
        step();
        check("b2b_b_err2", 32'({bus.hready, bus.hresp}), 32'b11);
        check("b2b_errcnt", 32'(err_cnt), 32'd3);
        step();

        // Master aborts with IDLE during ERR2
        drive(32'h6000_0000, HTRANS_NONSEQ);
        step();
        step();
        drive(32'h6000_0000, HTRANS_IDLE);
        step();
        check("abort_state", 32'({bus.hready, bus.hresp}), 32'b10);
        check("abort_errcnt", 32'(err_cnt), 32'd4);

        // Reset mid-ERR1
        drive(32'h6000_0000, HTRANS_NONSEQ);
        step();
        drive(32'h3000_0000, HTRANS_IDLE);
        check("pre_rst_hready", 32'(bus.hready), 32'd0);
        #2;
        hresetn = 1'b0;
        #1;
        check("midrst_hready", 32'(bus.hready), 32'd1);
        check("midrst_hresp",  32'(bus.hresp),  32'd0);
        check("midrst_errcnt", 32'(err_cnt),    32'd0);
        check("midrst_hsel",   32'(bus.hsel),   32'b1000);
        @(negedge hclk);
        hresetn = 1'b1;
        step();
        check("post_rst_hready", 32'(bus.hready), 32'd1);

        // Saturation: 260 back-to-back unmapped NONSEQs
        drive(32'h6000_0000, HTRANS_NONSEQ);
        for (int i = 0; i < 520; i++) step();
        drive(32'h0000_0000, HTRANS_IDLE);
        step();
        step();
        step();
        check("sat_errcnt", 32'(err_cnt), 32'hFF);

        @(negedge hclk);
        run_cmp = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
